beat_sequencer: RTL and testbench
=================================

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_BEAT, default 25_000_000: clk cycles per beat, legal range 2 or more.
REQ-002 SHALL have parameter COUNT_IN_BEATS, default 4: silent lead-in beats before beat 1, legal range 0..7.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle pulse that begins a song.
REQ-006 SHALL have port pause, input, 1 bit: one-cycle pulse that toggles between PLAY and PAUSE.
REQ-007 SHALL have port stop, input, 1 bit: one-cycle pulse that aborts to IDLE.
REQ-008 SHALL have port beat_cnt, output, 7 bits: current song beat, 0 when not playing, 1..96 during the song; feeds the beat-to-note lookup.
REQ-009 SHALL have port beat_tick, output, 1 bit: one-cycle pulse in the cycle beat_cnt takes a new nonzero value.
REQ-010 SHALL have port count_in, output, 3 bits: lead-in beats remaining, 0 outside COUNT_IN.
REQ-011 SHALL have port playing, output, 1 bit: high in PLAY only.
REQ-012 SHALL have port done, output, 1 bit: high in DONE only.

Function
REQ-013 SHALL implement states IDLE, COUNT_IN, PLAY, PAUSE and DONE.
REQ-014 SHALL keep a divider counting 0..TICKS_PER_BEAT-1. "Terminal" means the cycle the divider equals TICKS_PER_BEAT-1. The divider SHALL clear on entry to COUNT_IN or PLAY from IDLE or DONE.
REQ-015 IDLE or DONE with start: next state SHALL be COUNT_IN with count_in=COUNT_IN_BEATS. If COUNT_IN_BEATS=0, next state SHALL be PLAY with beat_cnt=1 and beat_tick=1.
REQ-016 COUNT_IN at terminal SHALL decrement count_in. When count_in is 1 at terminal, next state SHALL be PLAY with beat_cnt=1, beat_tick=1, count_in=0.
REQ-017 PLAY at terminal with beat_cnt below 96 SHALL increment beat_cnt and pulse beat_tick.
REQ-018 PLAY at terminal with beat_cnt=96 SHALL go to DONE. beat_cnt SHALL hold 96 in DONE, with no beat_tick.
REQ-019 PLAY with pause SHALL go to PAUSE. The divider and beat_cnt SHALL freeze.
REQ-020 PAUSE with pause SHALL return to PLAY and resume the divider from its frozen value.
REQ-021 pause SHALL be ignored outside PLAY and PAUSE.
REQ-022 stop in any state SHALL give IDLE next cycle, with beat_cnt=0, count_in=0 and the divider at 0.
REQ-023 When inputs are simultaneous, priority SHALL be stop > start > pause.
REQ-024 start SHALL be ignored in COUNT_IN, PLAY and PAUSE.
REQ-025 The divider width SHALL be $clog2(TICKS_PER_BEAT). The divider SHALL never exceed TICKS_PER_BEAT-1.
REQ-026 All outputs SHALL be registered.
REQ-027 beat_tick SHALL never be high for two consecutive cycles.

Reset
REQ-028 With rst_n low, state SHALL be IDLE immediately, regardless of clk.
REQ-029 With rst_n low, beat_cnt, count_in, the divider, beat_tick, playing and done SHALL all be 0.
REQ-030 Reset asserted mid-song SHALL discard all progress. After release, the block SHALL wait for start.

Configuration
REQ-031 Macro BNW_SONG_LOOP_EN, when defined: PLAY at terminal with beat_cnt=96 SHALL load beat_cnt=1 and pulse beat_tick while staying in PLAY. DONE SHALL be unreachable and done SHALL stay 0.
REQ-032 Macro BNW_SONG_LOOP_EN, when undefined: behaviour SHALL be per REQ-018.

Structure
REQ-033 Shared package bnw_pkg SHALL hold BEAT_W=7, LAST_BEAT=96 and the state enum type. No literal 96 SHALL appear in this module.
REQ-034 The divider SHALL be a sub-module beat_divider with inputs clk, rst_n, en and clr, and output term.

Verification
All scenarios use TICKS_PER_BEAT=4 and COUNT_IN_BEATS=2.
REQ-035 Reset: hold rst_n low for 3 cycles -> beat_cnt=0, count_in=0, playing=0, done=0, beat_tick=0.
REQ-036 Full song:
- start at cycle T -> count_in=2 at T+1.
- beat_cnt=1 with beat_tick at T+9.
- beat_cnt=96 at T+389.
- done=1 at T+393.
REQ-037 Pause: pause at the cycle after beat_cnt becomes 10; wait 20 cycles; pause again -> beat_cnt holds 10 throughout, then 11 exactly 4 cycles after the pause resume.
REQ-038 Simultaneous stop and start during PLAY at beat 40 -> IDLE next cycle with beat_cnt=0. A later start restarts the lead-in at count_in=2.
REQ-039 rst_n driven low mid-cycle at beat 50 -> beat_cnt=0 before the next clk edge. After release, no beat_tick until start.
REQ-040 With BNW_SONG_LOOP_EN defined: after beat 96, beat_cnt=1 with beat_tick 4 cycles later and playing=1; done never asserts over 2 loops.

Source files
------------

// File: rtl/bnw_pkg.sv
// bnw_pkg: shared constants and types for the beat sequencer.
//   BEAT_W      - width of the song beat counter
//   CIN_W       - width of the lead-in beat counter
//   LAST_BEAT   - final beat number of the song
//   bnw_state_e - sequencer state encoding
package bnw_pkg;

    localparam int unsigned BEAT_W = 7;
    localparam int unsigned CIN_W  = 3;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(96);

    typedef enum logic [2:0] {
        StIdle,
        StCountIn,
        StPlay,
        StPause,
        StDone
    } bnw_state_e;

endpackage

// File: rtl/beat_divider.sv
// beat_divider: free-running tick divider that counts 0..TICKS-1 while enabled.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   en    - advance the count this cycle
//   clr   - force the count to 0 (wins over en)
//   term  - count is at TICKS-1 (last tick of the beat)
module beat_divider #(
    parameter int unsigned TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic term
);

    localparam int unsigned DIV_W = (TICKS > 2) ? $clog2(TICKS) : 1;

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign term = (cnt_q == DIV_W'(TICKS - 1));

    // Wrap at the terminal value so the count never exceeds TICKS-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = term ? '0 : cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// beat_sequencer: song beat sequencer with lead-in, pause and stop.
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - pulse: begin a song from IDLE or DONE
//   pause     - pulse: toggle PLAY <-> PAUSE
//   stop      - pulse: abort to IDLE
//   beat_cnt  - current song beat (0 when not playing)
//   beat_tick - pulse when beat_cnt takes a new nonzero value
//   count_in  - lead-in beats remaining
//   playing   - high in PLAY
//   done      - high in DONE
// Optional: define BNW_SONG_LOOP_EN to wrap from the last beat back to beat 1
// instead of finishing in DONE.
module beat_sequencer
    import bnw_pkg::*;
#(
    parameter int unsigned TICKS_PER_BEAT = 25_000_000,
    parameter int unsigned COUNT_IN_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic [BEAT_W-1:0] beat_cnt,
    output logic              beat_tick,
    output logic [CIN_W-1:0]  count_in,
    output logic              playing,
    output logic              done
);

    bnw_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CIN_W-1:0]  cin_q, cin_d;
    logic              tick_q, tick_d;
    logic              playing_q, playing_d;
    logic              done_q, done_d;

    logic div_en;
    logic div_clr;
    logic div_term;

    beat_divider #(
        .TICKS(TICKS_PER_BEAT)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (div_en),
        .clr  (div_clr),
        .term (div_term)
    );

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cin_d   = cin_q;
        tick_d  = 1'b0;
        div_en  = 1'b0;
        div_clr = 1'b0;

        if (stop) begin
            state_d = StIdle;
            beat_d  = '0;
            cin_d   = '0;
            div_clr = 1'b1;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        div_clr = 1'b1;
                        if (COUNT_IN_BEATS == 0) begin
                            state_d = StPlay;
                            beat_d  = BEAT_W'(1);
                            cin_d   = '0;
                            tick_d  = 1'b1;
                        end else begin
                            state_d = StCountIn;
                            beat_d  = '0;
                            cin_d   = CIN_W'(COUNT_IN_BEATS);
                        end
                    end
                end
                StCountIn: begin
                    div_en = 1'b1;
                    if (div_term) begin
                        if (cin_q == CIN_W'(1)) begin
                            state_d = StPlay;
                            cin_d   = '0;
                            beat_d  = BEAT_W'(1);
                            tick_d  = 1'b1;
                        end else begin
                            cin_d = cin_q - CIN_W'(1);
                        end
                    end
                end
                StPlay: begin
                    // Pause freezes the divider on this edge so a resume
                    // restarts exactly where the beat was interrupted.
                    if (pause) begin
                        state_d = StPause;
                    end else begin
                        div_en = 1'b1;
                        if (div_term) begin
                            if (beat_q == LAST_BEAT) begin
`ifdef BNW_SONG_LOOP_EN
                                beat_d = BEAT_W'(1);
                                tick_d = 1'b1;
`else
                                state_d = StDone;
`endif
                            end else begin
                                beat_d = beat_q + BEAT_W'(1);
                                tick_d = 1'b1;
                            end
                        end
                    end
                end
                StPause: begin
                    if (pause) begin
                        state_d = StPlay;
                    end
                end
                default: begin
                    state_d = StIdle;
                    beat_d  = '0;
                    cin_d   = '0;
                    div_clr = 1'b1;
                end
            endcase
        end

        playing_d = (state_d == StPlay);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            cin_q     <= '0;
            tick_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            cin_q     <= cin_d;
            tick_q    <= tick_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign beat_cnt  = beat_q;
    assign beat_tick = tick_q;
    assign count_in  = cin_q;
    assign playing   = playing_q;
    assign done      = done_q;

endmodule

// File: tb/tb_beat_sequencer.sv
module tb_beat_sequencer;

    localparam int TPB  = 4;
    localparam int CIN  = 2;
    localparam int SONG = 96;
    localparam int LEAD = CIN * TPB;
`ifdef BNW_SONG_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam int MIdle = 0, MRun = 1, MPaused = 2, MDone = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, pause, stop;
    logic [6:0] beat_cnt;
    logic       beat_tick;
    logic [2:0] count_in;
    logic       playing, done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: song position is the number of running cycles since start.
    int m_mode = MIdle;
    int m_t    = 0;
    bit m_adv  = 1'b0;

    beat_sequencer #(
        .TICKS_PER_BEAT(TPB),
        .COUNT_IN_BEATS(CIN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .beat_cnt (beat_cnt),
        .beat_tick(beat_tick),
        .count_in (count_in),
        .playing  (playing),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic int exp_beat();
        if (m_mode == MIdle) return 0;
        if (m_mode == MDone) return SONG;
        if (m_t < LEAD) return 0;
        return ((m_t - LEAD) / TPB) % SONG + 1;
    endfunction

    function automatic int exp_cin();
        if ((m_mode == MRun || m_mode == MPaused) && m_t < LEAD) return CIN - m_t / TPB;
        return 0;
    endfunction

    function automatic int exp_tick();
        return (m_adv && m_mode == MRun && m_t >= LEAD && (m_t - LEAD) % TPB == 0) ? 1 : 0;
    endfunction

    task automatic model_edge(input bit s, input bit p, input bit x);
        m_adv = 1'b0;
        if (x) begin
            m_mode = MIdle;
        end else if (s && (m_mode == MIdle || m_mode == MDone)) begin
            m_mode = MRun;
            m_t    = 0;
            m_adv  = 1'b1;
        end else if (m_mode == MRun) begin
            if (p && m_t >= LEAD) begin
                m_mode = MPaused;
            end else begin
                m_t++;
                m_adv = 1'b1;
                if (!LOOP && m_t >= LEAD && (m_t - LEAD) / TPB >= SONG) m_mode = MDone;
            end
        end else if (m_mode == MPaused && p) begin
            m_mode = MRun;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("beat_cnt", 32'(beat_cnt), exp_beat());
        chk("beat_tick", 32'(beat_tick), exp_tick());
        chk("count_in", 32'(count_in), exp_cin());
        chk("playing", 32'(playing), (m_mode == MRun && m_t >= LEAD) ? 1 : 0);
        chk("done", 32'(done), (m_mode == MDone) ? 1 : 0);
    endtask

    // Called at posedge+1; inputs are held across exactly one rising edge.
    task automatic step(input bit s, input bit p, input bit x);
        start = s;
        pause = p;
        stop  = x;
        @(posedge clk);
        model_edge(s, p, x);
        #1;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
        check_all();
    endtask

    task automatic run_to_beat(input int target);
        bit hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (exp_beat() == target && exp_tick() == 1) hit = 1'b1;
        end
        chk("reach_beat", 32'(hit), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_beat", 32'(beat_cnt), 0);
        chk("rst_cin", 32'(count_in), 0);
        chk("rst_play", 32'(playing), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tick", 32'(beat_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b0);
        #1;
        check_all();

        // Full song
        step(1'b1, 1'b0, 1'b0);
        chk("T1_cin", 32'(count_in), 2);
        repeat (8) step(1'b0, 1'b0, 1'b0);
        chk("T9_beat", 32'(beat_cnt), 1);
        chk("T9_tick", 32'(beat_tick), 1);
        repeat (380) step(1'b0, 1'b0, 1'b0);
        chk("T389_beat", 32'(beat_cnt), 96);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        if (LOOP) begin
            chk("loop_beat", 32'(beat_cnt), 1);
            chk("loop_tick", 32'(beat_tick), 1);
            chk("loop_play", 32'(playing), 1);
            for (int i = 0; i < 2 * SONG * TPB; i++) begin
                step(1'b0, 1'b0, 1'b0);
                chk("loop_nodone", 32'(done), 0);
            end
        end else begin
            chk("T393_done", 32'(done), 1);
            chk("T393_beat", 32'(beat_cnt), 96);
            repeat (5) step(1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            chk("restart_cin", 32'(count_in), 2);
        end

        // Pause / resume
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        run_to_beat(10);
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("pause_hold", 32'(beat_cnt), 10);
        end
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        chk("resume_hold", 32'(beat_cnt), 10);
        step(1'b0, 1'b0, 1'b0);
        chk("resume_beat", 32'(beat_cnt), 11);
        chk("resume_tick", 32'(beat_tick), 1);

        // Stop and start together at beat 40
        run_to_beat(40);
        step(1'b1, 1'b0, 1'b1);
        chk("stop_beat", 32'(beat_cnt), 0);
        chk("stop_play", 32'(playing), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("stop_restart", 32'(count_in), 2);

        // Asynchronous reset mid-cycle at beat 50
        run_to_beat(50);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_beat", 32'(beat_cnt), 0);
        chk("arst_play", 32'(playing), 0);
        m_mode = MIdle;
        m_adv  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(1'b0, 1'b0, 1'b0);
        #1;
        check_all();
        for (int i = 0; i < 12; i++) begin
            step(1'b0, i[0], 1'b0);
            chk("arst_notick", 32'(beat_tick), 0);
        end

        // Random control traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
